// File: rtl/dma_priority_resolver.sv
// N-channel DMA request arbiter: masks DREQ, raises HRQ, latches one winner on HLDA
// and holds it until svc_done. Rotating priority is built only with DMA_ROTATE_PRIORITY_EN.
module dma_priority_resolver #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] dreq,
  input  logic [NUM_CH-1:0] mask,
  input  logic              rot_mode,
  input  logic              hlda,
  input  logic              svc_done,
  output logic              hrq,
  output logic [NUM_CH-1:0] valid_dreq,
  output logic              validDACK,
  output logic [CH_W-1:0]   grant_ch,
  output logic [CH_W-1:0]   top_ch
);

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t            state_q, state_d;
  logic              hrq_q, hrq_d;
  logic              dack_q, dack_d;
  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   top_cur;
  logic [NUM_CH-1:0] pend;
  logic [CH_W-1:0]   win_ch;
  logic              win_found;
  int unsigned       scan_idx;
  logic [CH_W-1:0]   scan_ch;

  assign pend = dreq & ~mask;

  // Scan from top_cur upward with wrap; first pending channel wins.
  always_comb begin
    win_ch    = '0;
    win_found = 1'b0;
    scan_idx  = 0;
    scan_ch   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      scan_idx = int'(top_cur) + i;
      if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
      scan_ch = CH_W'(scan_idx);
      if (!win_found && pend[scan_ch]) begin
        win_found = 1'b1;
        win_ch    = scan_ch;
      end
    end
  end

`ifdef DMA_ROTATE_PRIORITY_EN
  logic [CH_W-1:0] top_q, top_d;

  always_comb begin
    top_d = top_q;
    if (!rot_mode)
      top_d = '0;
    else if (state_q == SVC && svc_done)
      top_d = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) top_q <= '0;
    else       top_q <= top_d;
  end

  assign top_cur = top_q;
`else
  logic rot_mode_unused;
  assign rot_mode_unused = rot_mode;
  assign top_cur         = '0;
`endif

  always_comb begin
    state_d = state_q;
    hrq_d   = hrq_q;
    dack_d  = dack_q;
    valid_d = valid_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (|pend && !hlda) begin
          state_d = REQ;
          hrq_d   = 1'b1;
        end
      end
      REQ: begin
        if (~|pend) begin
          state_d = IDLE;
          hrq_d   = 1'b0;
        end else if (hlda) begin
          state_d         = SVC;
          dack_d          = 1'b1;
          grant_d         = win_ch;
          valid_d         = '0;
          valid_d[win_ch] = 1'b1;
        end
      end
      SVC: begin
        if (svc_done) begin
          state_d = IDLE;
          hrq_d   = 1'b0;
          dack_d  = 1'b0;
          valid_d = '0;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      hrq_q   <= 1'b0;
      dack_q  <= 1'b0;
      valid_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      hrq_q   <= hrq_d;
      dack_q  <= dack_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign hrq        = hrq_q;
  assign validDACK  = dack_q;
  assign valid_dreq = valid_q;
  assign grant_ch   = grant_q;
  assign top_ch     = top_cur;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Bench for dma_priority_resolver (NUM_CH=4): directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_dma_priority_resolver;

  localparam int N = 4;
`ifdef DMA_ROTATE_PRIORITY_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [N-1:0] dreq = '0;
  logic [N-1:0] mask = '0;
  logic         rot_mode = 1'b0;
  logic         hlda = 1'b0;
  logic         svc_done = 1'b0;
  logic         hrq;
  logic [N-1:0] valid_dreq;
  logic         validDACK;
  logic [1:0]   grant_ch;
  logic [1:0]   top_ch;

  dma_priority_resolver #(.NUM_CH(N)) dut (
    .CLK(CLK), .RESET(RESET), .dreq(dreq), .mask(mask), .rot_mode(rot_mode),
    .hlda(hlda), .svc_done(svc_done), .hrq(hrq), .valid_dreq(valid_dreq),
    .validDACK(validDACK), .grant_ch(grant_ch), .top_ch(top_ch)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: hold request flag, granted channel (-1 = none), priority head.
  int m_hrq = 0;
  int m_g   = -1;
  int m_top = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int winner(input int p, input int top);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (top + k) % N;
      if (((p >> c) & 1) == 1) return c;
    end
    return -1;
  endfunction

  task automatic model_edge(input int d, input int m, input int r, input int h,
                            input int s, input int rst);
    int pend;
    int old_top;
    pend    = d & ~m & ((1 << N) - 1);
    old_top = m_top;
    if (rst != 0) begin
      m_hrq = 0; m_g = -1; m_top = 0;
    end else begin
      if (!ROT_EN || r == 0) m_top = 0;
      if (m_g >= 0) begin
        if (s != 0) begin
          if (ROT_EN && r != 0) m_top = (m_g + 1) % N;
          m_g = -1; m_hrq = 0;
        end
      end else if (m_hrq != 0) begin
        if (pend == 0) m_hrq = 0;
        else if (h != 0) m_g = winner(pend, old_top);
      end else if (pend != 0 && h == 0) begin
        m_hrq = 1;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] d, input logic h, input logic s, input logic rst);
    dreq = d; hlda = h; svc_done = s; RESET = rst;
    @(posedge CLK);
    model_edge(int'(d), int'(mask), int'(rot_mode), int'(h), int'(s), int'(rst));
    #1;
    check("hrq",        hrq,        m_hrq);
    check("validDACK",  validDACK,  (m_g >= 0) ? 1 : 0);
    check("valid_dreq", valid_dreq, (m_g >= 0) ? (1 << m_g) : 0);
    check("grant_ch",   grant_ch,   (m_g >= 0) ? m_g : 0);
    check("top_ch",     top_ch,     m_top);
  endtask

  // Request, wait for hrq (bounded), hold off hlda for 'delay' cycles, serve, release.
  task automatic serve(input logic [N-1:0] d, input int delay, output int g);
    int n;
    n = 0;
    g = -1;
    step(d, 1'b0, 1'b0, 1'b0);
    while (hrq !== 1'b1 && n < 8) begin
      step(d, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (hrq !== 1'b1) check("hrq_timeout", 0, 1);
    repeat (delay) step(d, 1'b0, 1'b0, 1'b0);
    step(d, 1'b1, 1'b0, 1'b0);
    if (validDACK === 1'b1) g = int'(grant_ch);
    step(d, 1'b1, 1'b0, 1'b0);
    step(d, 1'b1, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int g;
    logic [N-1:0] rd, rm;
    logic rh;

    #1;
    step(4'hF, 1'b0, 1'b0, 1'b1);
    step(4'hF, 1'b0, 1'b0, 1'b1);
    check("reset_hrq", hrq, 0);
    step(4'hF, 1'b0, 1'b0, 1'b0);
    check("hrq_after_reset", hrq, 1);
    step(4'hF, 1'b1, 1'b0, 1'b0);
    check("first_grant", grant_ch, 0);
    step(4'hF, 1'b1, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);

    rot_mode = 1'b0;
    serve(4'b1010, 1, g);
    check("fixed_grant", g, 1);
    check("fixed_top", top_ch, 0);

    rot_mode = 1'b1;
    serve(4'b1000, 0, g);
    check("rot_ch3", g, 3);
`ifdef DMA_ROTATE_PRIORITY_EN
    check("rot_wrap_top", top_ch, 0);
    serve(4'b1001, 0, g);
    check("rot_second_ch0", g, 0);
    check("rot_top1", top_ch, 1);
    serve(4'b1001, 0, g);
    check("rot_from1_ch3", g, 3);
`else
    serve(4'b0010, 0, g);
    check("nomacro_ch1", g, 1);
    check("nomacro_top", top_ch, 0);
`endif
    rot_mode = 1'b0;
    step('0, 1'b0, 1'b0, 1'b0);

    // Mask withdraws the request while in REQ
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    check("mask_hrq_up", hrq, 1);
    mask = 4'b0100;
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    check("mask_hrq_down", hrq, 0);
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    check("mask_no_grant", validDACK, 0);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    mask = '0;
    step('0, 1'b0, 1'b0, 1'b0);

    // No preemption, then reset in the middle of service
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    check("svc_ch2", grant_ch, 2);
    repeat (3) step(4'b0101, 1'b1, 1'b0, 1'b0);
    check("nopreempt", grant_ch, 2);
    step(4'b0101, 1'b1, 1'b0, 1'b1);
    check("midreset_dack", validDACK, 0);
    check("midreset_valid", valid_dreq, 0);
    step('0, 1'b0, 1'b0, 1'b0);

    // Random traffic with a host that follows hrq with random latency
    rh = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rd = N'($urandom);
      rm = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      mask = rm;
      if ($urandom_range(0, 19) == 0) rot_mode = ~rot_mode;
      if (m_hrq != 0) begin
        if ($urandom_range(0, 1) == 0) rh = 1'b1;
      end else if ($urandom_range(0, 9) < 7) begin
        rh = 1'b0;
      end
      step(($urandom_range(0, 3) == 0) ? '0 : rd, rh,
           ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
           ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
